// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready channel between
// the fetch stage (master) and instruction memory (slave).
interface fetch_stage_if;
  logic        Fo_imemReq;
  logic [31:0] Fo_imemAddr;
  logic        Fi_imemReady;
  logic [31:0] Fi_imemRdata;

  modport master (
    output Fo_imemReq,
    output Fo_imemAddr,
    input  Fi_imemReady,
    input  Fi_imemRdata
  );

  modport slave (
    input  Fo_imemReq,
    input  Fo_imemAddr,
    output Fi_imemReady,
    output Fi_imemRdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem request FSM (WAIT/KILL/HOLD), IF/ID register.
// FETCH_PERF_CNT_EN enables the fetch/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Di_stall,
  input  logic          Di_flush,
  input  logic [1:0]    Ei_PCSrc,
  input  logic [31:0]   Ei_PCTarget,
  input  logic [31:0]   Ei_ALUOut,
  fetch_stage_if.master imem,
  output logic [31:0]   Do_instr,
  output logic [31:0]   Do_PC,
  output logic [31:0]   Do_PCPlus4,
  output logic          Do_valid,
  output logic [31:0]   Fo_fetchCount,
  output logic [31:0]   Fo_bubbleCount
);

  typedef enum logic [1:0] {
    WAIT,
    KILL,
    HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  if_id_t      ifid_q, ifid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        done;
  logic        new_v;
  logic [31:0] new_instr;
  logic [31:0] new_pc;
  logic        sel_kill;
  logic        sel_hold;
  logic        sel_load;
  logic        sel_bub;

  assign imem.Fo_imemReq  = rst_n && (state_q != HOLD);
  assign imem.Fo_imemAddr = pc_q;

  // Redirect decode and transfer completion
  always_comb begin
    redirect = (Ei_PCSrc != 2'b00);
    target   = Ei_PCTarget;
    if (Ei_PCSrc == 2'b10) target = Ei_ALUOut & ~32'd1;
    pc_plus4 = pc_q + 32'd4;
    done     = imem.Fo_imemReq && imem.Fi_imemReady;
  end

  // Next state, PC, kill target and skid buffer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    new_v       = 1'b0;
    new_instr   = imem.Fi_imemRdata;
    new_pc      = pc_q;
    unique case (state_q)
      WAIT: begin
        if (done) begin
          if (redirect) begin
            pc_d = target;
          end else if (Di_stall) begin
            buf_instr_d = imem.Fi_imemRdata;
            buf_pc_d    = pc_q;
            pc_d        = pc_plus4;
            state_d     = HOLD;
          end else begin
            new_v = 1'b1;
            pc_d  = pc_plus4;
          end
        end else if (redirect) begin
          tgt_d   = target;
          state_d = KILL;
        end
      end
      KILL: begin
        if (redirect) tgt_d = target;
        if (done) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = WAIT;
        end else if (!Di_stall) begin
          new_v     = 1'b1;
          new_instr = buf_instr_q;
          new_pc    = buf_pc_q;
          state_d   = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  // IF/ID select: flush/redirect > stall > new instr > bubble
  always_comb begin
    sel_kill = Di_flush | redirect;
    sel_hold = !sel_kill && Di_stall;
    sel_load = !sel_kill && !Di_stall && new_v;
    sel_bub  = !sel_kill && !Di_stall && !new_v;
    ifid_d   = ifid_q;
    unique case (1'b1)
      sel_kill, sel_bub: begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end
      sel_hold: ifid_d = ifid_q;
      sel_load: begin
        ifid_d.instr = new_instr;
        ifid_d.pc    = new_pc;
        ifid_d.pc4   = new_pc + 32'd4;
        ifid_d.valid = 1'b1;
      end
      default: ifid_d = ifid_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= '0;
      ifid_q.pc4   <= '0;
      ifid_q.valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      ifid_q      <= ifid_d;
    end
  end

  assign Do_instr   = ifid_q.instr;
  assign Do_PC      = ifid_q.pc;
  assign Do_PCPlus4 = ifid_q.pc4;
  assign Do_valid   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count valid IF/ID loads and bubble loads; stall holds excluded
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (sel_load) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (sel_kill || sel_bub) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign Fo_fetchCount  = fetch_cnt_q;
  assign Fo_bubbleCount = bubble_cnt_q;
`else
  assign Fo_fetchCount  = 32'd0;
  assign Fo_bubbleCount = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction presented on a bubble.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Di_stall  in  1  hold the IF/ID register and the PC.
REQ-006 Di_flush  in  1  load a bubble into IF/ID.
REQ-007 Ei_PCSrc  in  2  redirect select: 00 = PC+4, 01 = Ei_PCTarget, 10 = Ei_ALUOut & ~1, 11 = treated as 01.
REQ-008 Ei_PCTarget  in  32  branch/JAL target.
REQ-009 Ei_ALUOut  in  32  JALR target before LSB clear.
REQ-010 Fo_imemReq  out  1  instruction-memory request.
REQ-011 Fo_imemAddr  out  32  fetch address.
REQ-012 Fi_imemReady  in  1  transfer completes in any cycle where Fo_imemReq && Fi_imemReady.
REQ-013 Fi_imemRdata  in  32  instruction data, valid in the completing cycle.
REQ-014 Do_instr, Do_PC, Do_PCPlus4  out  32 each  IF/ID register contents.
REQ-015 Do_valid  out  1  IF/ID holds a real instruction.
REQ-016 Fo_fetchCount, Fo_bubbleCount  out  32 each  performance counters (see Configuration).

Function
REQ-017 Redirect SHALL equal (Ei_PCSrc != 2'b00); redirect target per REQ-007.
REQ-018 FSM states SHALL be WAIT, KILL and HOLD.
REQ-019 WAIT: Fo_imemReq=1 and Fo_imemAddr=PC.
  - On completion with no redirect and no Di_stall: IF/ID <= {rdata, PC, PC+4, valid=1}; PC <= PC+4; stay in WAIT (back-to-back, 1 instruction/cycle when ready is held high).
  - On completion with Di_stall=1 and no redirect: rdata/PC go to a one-entry buffer; PC <= PC+4; go to HOLD.
  - On completion with redirect: discard rdata; PC <= target; stay in WAIT.
  - No completion and redirect: latch target; go to KILL.
  - No completion and no redirect: stay in WAIT.
REQ-020 KILL: Fo_imemReq=1 and Fo_imemAddr is unchanged (a request SHALL never be withdrawn or have its address changed before completion).
  - On completion: discard data; PC <= latched target; go to WAIT.
  - A further redirect while in KILL overwrites the latched target, including in the completion cycle.
REQ-021 HOLD: Fo_imemReq=0.
  - When Di_stall=0: IF/ID <= buffer (valid=1); go to WAIT.
  - Redirect in HOLD: drop the buffer; PC <= target; go to WAIT.
REQ-022 IF/ID update priority SHALL be: Di_flush or redirect (load bubble) > Di_stall (hold) > new instruction > bubble.
REQ-023 A bubble SHALL set Do_valid=0 and Do_instr=NOP_INSTR; Do_PC and Do_PCPlus4 hold their previous values.
REQ-024 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-025 While rst_n=0:
  - PC=RESET_PC, state=WAIT;
  - Do_valid=0, Do_instr=NOP_INSTR, Do_PC=0, Do_PCPlus4=0;
  - buffer and latched target cleared;
  - counters=0.
REQ-026 Fo_imemReq SHALL be 0 while rst_n=0 and 1 in the first cycle after release. Reset mid-transfer abandons the transfer; the memory SHALL tolerate this.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN.
  - Defined: Fo_fetchCount increments on every IF/ID load with valid=1; Fo_bubbleCount increments on every IF/ID load of a bubble (stall-hold cycles excluded); both wrap at 2^32.
  - Undefined: both ports are present and tied to 0, and no counter flops exist.

Verification
REQ-028 Reset release with ready held at 1 -> addresses 0, 4, 8 on successive cycles; Do_valid=1 from cycle 2; Do_PC=0, 4, 8.
REQ-029 Ready low for 3 cycles on address 0x10 -> Fo_imemAddr stays 0x10 for 4 cycles; 3 bubbles loaded into IF/ID; Fo_bubbleCount=3 (macro defined).
REQ-030 Ei_PCSrc=01 with target 0x100 during a pending fetch of 0x20 -> KILL state, address 0x20 held until ready; next request is 0x100; 0x20's data never sets Do_valid.
REQ-031 Completion at 0x40 while Di_stall=1 for 2 cycles -> Fo_imemReq=0 during HOLD; IF/ID loads 0x40's instruction in the cycle after Di_stall falls.
REQ-032 Ei_PCSrc=10 with Ei_ALUOut=0x203 in HOLD -> buffer dropped; next Fo_imemAddr=0x202; Do_valid=0 for that cycle.
